// File: rtl/cpu_pkg.sv
// Shared widths, instruction type and the default boot program image
// for the 16-bit CPU fetch path.
package cpu_pkg;

   localparam int unsigned ADDR_W    = 16;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned IMAGE_LEN = 24;

   typedef logic [DATA_W-1:0] instr_t;

   localparam instr_t NOP = 16'h0000;

   localparam instr_t PROGRAM_IMAGE [IMAGE_LEN] = '{
      16'h1001, 16'h1102, 16'h2012, 16'h3113,
      16'h4204, 16'h5305, 16'h6016, 16'h7127,
      16'h8238, 16'h9349, 16'hA45A, 16'hB56B,
      16'hC67C, 16'hD78D, 16'hE89E, 16'hF9AF,
      16'h0AB0, 16'h1BC1, 16'h2CD2, 16'h3DE3,
      16'h4EF4, 16'h5F05, 16'h6A16, 16'h7B27
   };

   // Words past the end of the image boot as NOP.
   function automatic instr_t image_word(input int unsigned i);
      if (i < IMAGE_LEN) return PROGRAM_IMAGE[i];
      return NOP;
   endfunction

endpackage

// File: rtl/instr_mem_if.sv
// Fetch/load bus for the instruction store. No handshake: the read is
// combinational on pc, and a load-port write takes effect at the next clock edge when we=1.
interface instr_mem_if;
   import cpu_pkg::*;

   logic [ADDR_W-1:0] pc;
   instr_t            instruction;
   logic              addr_err;
   logic              we;
   logic [ADDR_W-1:0] wr_addr;
   instr_t            wr_data;

   modport master (
      output pc, we, wr_addr, wr_data,
      input  instruction, addr_err
   );

   modport slave (
      input  pc, we, wr_addr, wr_data,
      output instruction, addr_err
   );

endinterface

// File: rtl/instr_mem.sv
// Word-organised instruction store: zero-latency read on a byte pc,
// program image restored on reset, synchronous load port for overwrites.
module instr_mem
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   instr_mem_if.slave  bus
);

   localparam int unsigned      IDX_W   = $clog2(DEPTH);
   localparam logic [ADDR_W-2:0] DEPTH_V = (ADDR_W-1)'(DEPTH);

   instr_t mem_q [DEPTH];
   instr_t mem_d [DEPTH];

   logic [ADDR_W-2:0] rd_idx;
   logic [ADDR_W-2:0] wr_idx;
   logic              rd_in_range;
   logic              wr_in_range;
   logic              unused_wr_lsb;

   // Byte addresses select words; bit 0 only matters for the alignment flag.
   assign rd_idx        = bus.pc[ADDR_W-1:1];
   assign wr_idx        = bus.wr_addr[ADDR_W-1:1];
   assign rd_in_range   = (rd_idx < DEPTH_V);
   assign wr_in_range   = (wr_idx < DEPTH_V);
   assign unused_wr_lsb = bus.wr_addr[0];

   always_comb begin
      mem_d = mem_q;
      if (bus.we && wr_in_range) begin
         mem_d[wr_idx[IDX_W-1:0]] = bus.wr_data;
      end
   end

   // Reset wins over a concurrent load-port write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= image_word(i);
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      bus.instruction = NOP;
      bus.addr_err    = 1'b0;
      if (!rst) begin
         if (rd_in_range) begin
            bus.instruction = mem_q[rd_idx[IDX_W-1:0]];
         end
         bus.addr_err = !rd_in_range || bus.pc[0];
      end
   end

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed fetch/load/reset steps followed by
// randomized traffic checked against an array model of the store.
module tb_instr_mem;

  localparam int DEPTH = 32;

  logic clk;
  logic rst;

  instr_mem_if bus ();

  instr_mem #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] img [24] = '{
    16'h1001, 16'h1102, 16'h2012, 16'h3113,
    16'h4204, 16'h5305, 16'h6016, 16'h7127,
    16'h8238, 16'h9349, 16'hA45A, 16'hB56B,
    16'hC67C, 16'hD78D, 16'hE89E, 16'hF9AF,
    16'h0AB0, 16'h1BC1, 16'h2CD2, 16'h3DE3,
    16'h4EF4, 16'h5F05, 16'h6A16, 16'h7B27
  };
  logic [15:0] model_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [$];
  logic        err_q [$];

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = (i < 24) ? img[i] : 16'h0000;
  endfunction

  function automatic void model_write(input logic [15:0] addr, input logic [15:0] data);
    int widx;
    widx = int'(addr) / 2;
    if (widx < DEPTH) model_mem[widx] = data;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] addr, input logic in_rst);
    int widx;
    widx = int'(addr) / 2;
    if (in_rst) return 16'h0000;
    if (widx >= DEPTH) return 16'h0000;
    return model_mem[widx];
  endfunction

  function automatic logic model_err(input logic [15:0] addr, input logic in_rst);
    if (in_rst) return 1'b0;
    return (int'(addr) / 2 >= DEPTH) || (addr % 2 == 1);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic check_read(input string tag, input logic [15:0] addr);
    bus.pc = addr;
    #2;
    exp_q.push_back(model_read(addr, rst));
    err_q.push_back(model_err(addr, rst));
    check16({tag, "_instr"}, bus.instruction, exp_q.pop_front());
    check1({tag, "_err"}, bus.addr_err, err_q.pop_front());
  endtask

  // ---------------- driver ----------------
  task automatic write_word(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.we      = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    model_write(addr, data);
  endtask

  task automatic sweep_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check_read(tag, 16'(2 * i));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    bus.pc      = 16'h0040;
    bus.we      = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // Reset held two clocks; outputs forced quiet even for a bad pc.
    @(negedge clk);
    check16("rst_instr", bus.instruction, 16'h0000);
    check1("rst_err", bus.addr_err, 1'b0);
    @(negedge clk);
    model_reset();
    rst = 1'b0;

    // 1: image fetch every 20 ns
    for (int i = 0; i < 24; i++) begin
      check_read("image", 16'(2 * i));
      #18;
    end
    // words past the image are NOP, last in-range word not flagged
    for (int i = 24; i < DEPTH; i++) begin
      @(negedge clk);
      check_read("tail", 16'(2 * i));
    end

    // 2: out of range
    @(negedge clk);
    check_read("oor_40", 16'h0040);
    check_read("oor_fffe", 16'hFFFE);

    // 3: misaligned
    check_read("mis_3", 16'h0003);
    check_read("mis_ffff", 16'hFFFF);
    check_read("mis_3f", 16'h003F);

    // 4: load port, odd address ignores bit 0
    write_word(16'h0006, 16'hA5C3);
    check_read("wr_6", 16'h0006);
    check16("wr_6_lit", bus.instruction, 16'hA5C3);
    write_word(16'h0007, 16'h5A3C);
    check_read("wr_7", 16'h0006);
    check16("wr_7_lit", bus.instruction, 16'h5A3C);

    // 5: same-word write/read, no bypass
    @(negedge clk);
    bus.pc      = 16'h0006;
    bus.we      = 1'b1;
    bus.wr_addr = 16'h0006;
    bus.wr_data = 16'h1234;
    #2;
    check16("rw_before", bus.instruction, 16'h5A3C);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    model_write(16'h0006, 16'h1234);
    check16("rw_after", bus.instruction, 16'h1234);

    // out-of-range writes dropped; high word written at boundary
    write_word(16'h0040, 16'hBEEF);
    write_word(16'hFFFE, 16'hDEAD);
    write_word(16'h003E, 16'hC0DE);
    sweep_all("after_wr");

    // 6: reset beats a concurrent write
    @(negedge clk);
    rst         = 1'b1;
    bus.we      = 1'b1;
    bus.wr_addr = 16'h0006;
    bus.wr_data = 16'hFFFF;
    bus.pc      = 16'h0006;
    #2;
    check16("rst6_instr", bus.instruction, 16'h0000);
    check1("rst6_err", bus.addr_err, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    bus.we = 1'b0;
    model_reset();
    check_read("post_rst_w3", 16'h0006);
    check16("post_rst_w3_lit", bus.instruction, img[3]);
    sweep_all("post_rst");

    // randomized mixed traffic with occasional mid-sequence reset
    for (int n = 0; n < 400; n++) begin
      logic        do_rst;
      logic [15:0] pc_v;
      logic [15:0] wa;
      logic [15:0] wd;
      logic        we_v;
      @(negedge clk);
      do_rst = ($urandom_range(0, 19) == 0);
      we_v   = ($urandom_range(0, 1) == 1);
      wa     = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h45));
      wd     = 16'($urandom);
      pc_v   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h45));
      rst         = do_rst;
      bus.we      = we_v;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      check_read("rand", pc_v);
      @(posedge clk);
      #1;
      if (do_rst) model_reset();
      else if (we_v) model_write(wa, wd);
    end
    @(negedge clk);
    rst    = 1'b0;
    bus.we = 1'b0;
    sweep_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
